divider: RTL

- Iterative radix-2 restoring divider for the RV32M divide group: DIV, DIVU, REM, REMU (funct3 100/101/110/111).
- Sits in the EX stage next to the multiply unit and uses the same ce/funct3/stall interface.
- Holds the ID/EX and EX/MEM pipeline registers via stall outputs while the operation is in flight.
- Produces the RISC-V-defined results for divide-by-zero and signed overflow on a short fast path.

---
 rtl/divider.sv | 135 +++++++++++++
 1 files changed

// File: rtl/divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Stalls the ID/EX and EX/MEM registers while an operation is in flight.
module divider #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ce,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] result,
   output logic            busy,
   output logic            done,
   output logic            stall_idex,
   output logic            stall_exmem
);

   localparam int unsigned CNT_W = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t            state, state_n;
   logic [XLEN-1:0]   rem, rem_n, quo, quo_n, divisor, divisor_n, result_n;
   logic [CNT_W-1:0]  count, count_n;
   logic              neg_q, neg_q_n, neg_r, neg_r_n, want_rem, want_rem_n;
   logic              done_n, busy_n;

   logic              start, signed_op, a_neg, b_neg, div_zero, overflow;
   logic [XLEN-1:0]   abs_a, abs_b;
   logic [XLEN:0]     sh, diff;

   // Operand decode used only on the start edge
   always_comb begin
      start     = ce & funct3[2];
      signed_op = ~funct3[0];
      a_neg     = signed_op & a[XLEN-1];
      b_neg     = signed_op & b[XLEN-1];
      abs_a     = a_neg ? -a : a;
      abs_b     = b_neg ? -b : b;
      div_zero  = (b == '0);
      overflow  = signed_op & (a == {1'b1, {(XLEN-1){1'b0}}}) & (&b);
      sh        = {rem, quo[XLEN-1]};
      diff      = sh - {1'b0, divisor};
   end

   // Next-state and datapath update
   always_comb begin
      state_n    = state;
      rem_n      = rem;
      quo_n      = quo;
      divisor_n  = divisor;
      count_n    = count;
      neg_q_n    = neg_q;
      neg_r_n    = neg_r;
      want_rem_n = want_rem;
      result_n   = result;
      done_n     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               want_rem_n = funct3[1];
               neg_q_n    = a_neg ^ b_neg;
               neg_r_n    = a_neg;
               quo_n      = abs_a;
               rem_n      = '0;
               count_n    = '0;
               divisor_n  = abs_b;
               if (div_zero) begin
                  result_n = funct3[1] ? a : '1;
                  state_n  = DONE;
                  done_n   = 1'b1;
               end else if (overflow) begin
                  result_n = funct3[1] ? '0 : a;
                  state_n  = DONE;
                  done_n   = 1'b1;
               end else begin
                  state_n  = CALC;
               end
            end
         end
         CALC: begin
            if (!diff[XLEN]) rem_n = diff[XLEN-1:0];
            else             rem_n = sh[XLEN-1:0];
            quo_n   = {quo[XLEN-2:0], ~diff[XLEN]};
            count_n = count + CNT_W'(1);
            if (count == CNT_W'(XLEN-1)) state_n = FIX;
         end
         FIX: begin
            if (want_rem) result_n = neg_r ? -rem : rem;
            else          result_n = neg_q ? -quo : quo;
            state_n = DONE;
            done_n  = 1'b1;
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         rem      <= '0;
         quo      <= '0;
         divisor  <= '0;
         count    <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         want_rem <= 1'b0;
         result   <= '0;
         done     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         rem      <= rem_n;
         quo      <= quo_n;
         divisor  <= divisor_n;
         count    <= count_n;
         neg_q    <= neg_q_n;
         neg_r    <= neg_r_n;
         want_rem <= want_rem_n;
         result   <= result_n;
         done     <= done_n;
         busy     <= busy_n;
      end
   end

   // Stalls drop in DONE so the instruction advances with its result
   always_comb begin
      stall_idex  = ((state == IDLE) & start) | (state == CALC) | (state == FIX);
      stall_exmem = stall_idex;
   end

endmodule
